// File: rtl/button_conditioner_pkg.sv
// Shared types and channel index names for the front-panel button conditioner.
// Imported by the channel and top modules.
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT,
        LONG
    } btn_state_e;

    localparam int BTN_SEL  = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DN   = 2;
    localparam int BTN_MODE = 3;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the panel pins and the mode/set controller.
// The master drives raw buttons; the slave (conditioner) returns the conditioned view.
interface button_conditioner_if #(
    parameter int N_BTN = 4
);
    logic [N_BTN-1:0] button;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    modport master (
        output button,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  button,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/button_conditioner_btn_channel.sv
// One button channel: synchronizer, debounce counter and press/long/repeat FSM.
// All outputs are registered; press/release pulse in the first cycle of the new debounced level.
module btn_channel
    import button_conditioner_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int HOLD_CYCLES     = 50000,
    parameter int REPEAT_CYCLES   = 10000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic button,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_p;
    logic [DW-1:0]          deb_cnt;
    logic [HW-1:0]          hold_cnt;
    logic [RW-1:0]          rep_cnt;
    btn_state_e             state;

    logic sync_out;
    logic differ;
    logic flip;
    logic rise;
    logic fall;

    // Debounce decision is combinational so the FSM reacts in the same edge as btn_level flips
    assign sync_out = sync_p[SYNC_STAGES-1];
    assign differ   = (sync_out != btn_level);
    assign flip     = differ && (deb_cnt == DEB_LAST);
    assign rise     = flip && sync_out;
    assign fall     = flip && !sync_out;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p      <= '0;
            deb_cnt     <= '0;
            hold_cnt    <= '0;
            rep_cnt     <= '0;
            state       <= IDLE;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            btn_long    <= 1'b0;
        end else begin
            sync_p      <= {sync_p[SYNC_STAGES-2:0], button};
            btn_press   <= 1'b0;
            btn_release <= 1'b0;

            if (!differ) begin
                deb_cnt <= '0;
            end else if (flip) begin
                deb_cnt   <= '0;
                btn_level <= sync_out;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end

            // A debounced fall overrides any hold/repeat expiry in the same cycle
            if (fall) begin
                state       <= IDLE;
                btn_release <= 1'b1;
                btn_long    <= 1'b0;
                hold_cnt    <= '0;
                rep_cnt     <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            state     <= PRESSED;
                            btn_press <= 1'b1;
                            hold_cnt  <= '0;
                        end
                    end
                    PRESSED: begin
                        if (hold_cnt == HOLD_LAST) begin
                            btn_long <= 1'b1;
                            hold_cnt <= '0;
                            if (REPEAT_EN) begin
                                btn_press <= 1'b1;
                                rep_cnt   <= '0;
                                state     <= REPEAT;
                            end else begin
                                state <= LONG;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    REPEAT: begin
                        if (rep_cnt == REP_LAST) begin
                            btn_press <= 1'b1;
                            rep_cnt   <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + 1'b1;
                        end
                    end
                    LONG: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Front-panel button conditioner: N_BTN independent channels feeding the time-setting controller.
// Channels whose REPEAT_MASK bit is set auto-repeat while held past the long-press point.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int               N_BTN           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 100,
    parameter int               HOLD_CYCLES     = 50000,
    parameter int               REPEAT_CYCLES   = 10000,
    parameter logic [N_BTN-1:0] REPEAT_MASK     = 4'b0110
) (
    input  logic                 clock,
    input  logic                 reset,
    button_conditioner_if.slave  bus
);

    logic [N_BTN-1:0] level_v;
    logic [N_BTN-1:0] press_v;
    logic [N_BTN-1:0] release_v;
    logic [N_BTN-1:0] long_v;

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        btn_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .REPEAT_CYCLES   (REPEAT_CYCLES),
            .REPEAT_EN       (REPEAT_MASK[i])
        ) u_ch (
            .clock       (clock),
            .reset       (reset),
            .button      (bus.button[i]),
            .btn_level   (level_v[i]),
            .btn_press   (press_v[i]),
            .btn_release (release_v[i]),
            .btn_long    (long_v[i])
        );
    end

    assign bus.btn_level   = level_v;
    assign bus.btn_press   = press_v;
    assign bus.btn_release = release_v;
    assign bus.btn_long    = long_v;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with shortened hold/repeat limits.
// Latency 102 cycles; long-press 500 cycles after press; repeat period 100 cycles; channels 1,2 repeat.
module tb_button_conditioner;

    logic clock = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [3:0] acc;

    always #2 clock = ~clock;

    button_conditioner_if #(.N_BTN(4)) bus ();

    button_conditioner #(
        .N_BTN           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (100),
        .HOLD_CYCLES     (500),
        .REPEAT_CYCLES   (100),
        .REPEAT_MASK     (4'b0110)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1);
            acc = acc | bus.btn_level | bus.btn_press | bus.btn_release | bus.btn_long;
        end
    endtask

    initial begin
        reset      = 1'b1;
        bus.button = 4'b0000;
        cyc(3);
        chk("rst_level",   bus.btn_level,   4'b0000);
        chk("rst_press",   bus.btn_press,   4'b0000);
        chk("rst_release", bus.btn_release, 4'b0000);
        chk("rst_long",    bus.btn_long,    4'b0000);
        reset = 1'b0;
        cyc(5);

        // single press/release on MODE
        bus.button = 4'b1000;
        cyc(101);
        chk("t1_level_101", bus.btn_level, 4'b0000);
        chk("t1_press_101", bus.btn_press, 4'b0000);
        cyc(1);
        chk("t1_level_102", bus.btn_level, 4'b1000);
        chk("t1_press_102", bus.btn_press, 4'b1000);
        cyc(1);
        chk("t1_press_103", bus.btn_press, 4'b0000);
        cyc(197);
        chk("t1_long_300",  bus.btn_long,  4'b0000);
        chk("t1_level_300", bus.btn_level, 4'b1000);
        bus.button = 4'b0000;
        cyc(101);
        chk("t1_level_rel101", bus.btn_level,   4'b1000);
        chk("t1_rel_rel101",   bus.btn_release, 4'b0000);
        cyc(1);
        chk("t1_level_rel102", bus.btn_level,   4'b0000);
        chk("t1_rel_rel102",   bus.btn_release, 4'b1000);
        cyc(1);
        chk("t1_rel_rel103",   bus.btn_release, 4'b0000);
        cyc(20);

        // glitches of 40 and 99 cycles are rejected
        acc = 4'b0000;
        bus.button = 4'b0010;
        watch(40);
        bus.button = 4'b0000;
        watch(200);
        bus.button = 4'b0010;
        watch(99);
        bus.button = 4'b0000;
        watch(200);
        chk("t2_glitch", acc, 4'b0000);

        // SEL (no repeat) and UP (repeat) held 650 cycles together
        bus.button = 4'b0011;
        cyc(101);
        chk("t3_press_101", bus.btn_press, 4'b0000);
        cyc(1);
        chk("t3_press_102", bus.btn_press, 4'b0011);
        chk("t3_level_102", bus.btn_level, 4'b0011);
        cyc(1);
        chk("t3_press_103", bus.btn_press, 4'b0000);
        cyc(498);
        chk("t3_long_601",  bus.btn_long,  4'b0000);
        chk("t3_press_601", bus.btn_press, 4'b0000);
        cyc(1);
        chk("t3_long_602",  bus.btn_long,  4'b0011);
        chk("t3_press_602", bus.btn_press, 4'b0010);
        cyc(1);
        chk("t3_press_603", bus.btn_press, 4'b0000);
        cyc(47);
        bus.button = 4'b0000;
        cyc(51);
        chk("t3_press_701", bus.btn_press, 4'b0000);
        cyc(1);
        chk("t3_press_702", bus.btn_press, 4'b0010);
        chk("t3_long_702",  bus.btn_long,  4'b0011);
        cyc(1);
        chk("t3_press_703", bus.btn_press, 4'b0000);
        cyc(48);
        chk("t3_long_751",  bus.btn_long,    4'b0011);
        chk("t3_rel_751",   bus.btn_release, 4'b0000);
        cyc(1);
        chk("t3_rel_752",   bus.btn_release, 4'b0011);
        chk("t3_long_752",  bus.btn_long,    4'b0000);
        chk("t3_level_752", bus.btn_level,   4'b0000);
        chk("t3_press_752", bus.btn_press,   4'b0000);
        cyc(1);
        chk("t3_rel_753",   bus.btn_release, 4'b0000);
        cyc(20);

        // UP and DN together; release lands on the second repeat expiry
        bus.button = 4'b0110;
        cyc(102);
        chk("t5_press_102", bus.btn_press, 4'b0110);
        chk("t5_level_102", bus.btn_level, 4'b0110);
        cyc(1);
        chk("t5_press_103", bus.btn_press, 4'b0000);
        cyc(499);
        chk("t5_press_602", bus.btn_press, 4'b0110);
        chk("t5_long_602",  bus.btn_long,  4'b0110);
        cyc(98);
        bus.button = 4'b0000;
        cyc(2);
        chk("t5_press_702", bus.btn_press, 4'b0110);
        cyc(99);
        chk("t5_press_801", bus.btn_press,   4'b0000);
        chk("t5_rel_801",   bus.btn_release, 4'b0000);
        chk("t5_long_801",  bus.btn_long,    4'b0110);
        cyc(1);
        chk("t5_rel_802",   bus.btn_release, 4'b0110);
        chk("t5_press_802", bus.btn_press,   4'b0000);
        chk("t5_long_802",  bus.btn_long,    4'b0000);
        cyc(1);
        chk("t5_rel_803",   bus.btn_release, 4'b0000);
        chk("t5_press_803", bus.btn_press,   4'b0000);
        cyc(20);

        // reset while DN is held in long-press
        bus.button = 4'b0100;
        cyc(102);
        chk("t6_press_102", bus.btn_press, 4'b0100);
        cyc(548);
        chk("t6_long_650",  bus.btn_long,  4'b0100);
        chk("t6_level_650", bus.btn_level, 4'b0100);
        reset = 1'b1;
        #1;
        chk("t6_rst_level", bus.btn_level, 4'b0000);
        chk("t6_rst_long",  bus.btn_long,  4'b0000);
        cyc(2);
        reset = 1'b0;
        cyc(101);
        chk("t6_level_101", bus.btn_level, 4'b0000);
        chk("t6_press_101", bus.btn_press, 4'b0000);
        cyc(1);
        chk("t6_level_102", bus.btn_level, 4'b0100);
        chk("t6_press_102b", bus.btn_press, 4'b0100);
        cyc(1);
        chk("t6_press_103", bus.btn_press, 4'b0000);
        bus.button = 4'b0000;
        cyc(110);
        chk("t6_level_end", bus.btn_level, 4'b0000);
        chk("t6_long_end",  bus.btn_long,  4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
